// File: rtl/key_schedule_gen_if.sv
// Handshake bundle between the key register / round datapath and key_schedule_gen.
// KEY_PARITY_CHECK_EN adds the parity_err status line.
interface key_schedule_gen_if;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic        subkey_ack;
  logic [55:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
`ifdef KEY_PARITY_CHECK_EN
  logic        parity_err;

  modport master (output start, key, decrypt, subkey_ack,
                  input  subkey, subkey_valid, round, busy, done, parity_err);
  modport slave  (input  start, key, decrypt, subkey_ack,
                  output subkey, subkey_valid, round, busy, done, parity_err);
`else
  modport master (output start, key, decrypt, subkey_ack,
                  input  subkey, subkey_valid, round, busy, done);
  modport slave  (input  start, key, decrypt, subkey_ack,
                  output subkey, subkey_valid, round, busy, done);
`endif
endinterface

// File: rtl/key_schedule_gen.sv
// Sequential DES key schedule: PC-1 then per-round C/D rotations, one C||D word per ack.
// Optional macro KEY_PARITY_CHECK_EN rejects keys with any even-parity byte.
module key_schedule_gen #(
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  key_schedule_gen_if.slave ks
);

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
  // Bit j set means round j+1 shifts by two; rounds 1, 2, 9 and 16 shift by one.
  localparam logic [15:0] SHIFT_TWO  = 16'b0111_1110_1111_1100;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mode_q, mode_d;
  logic        key_ok;
  logic [55:0] cd0;

  assign cd0 = pc1(ks.key);

`ifdef KEY_PARITY_CHECK_EN
  logic perr_q, perr_d;
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) if (!(^ks.key[8*b +: 8])) key_ok = 1'b0;
  end
  assign ks.parity_err = perr_q;
`else
  assign key_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ks.start) begin
          if (!key_ok) begin
`ifdef KEY_PARITY_CHECK_EN
            perr_d = 1'b1;
`endif
          end else begin
            mode_d  = ks.decrypt;
            // Decrypt begins at CD16, which equals CD0 after a full 28-bit turn.
            cd_d    = ks.decrypt ? cd0 : {rotl(cd0[55:28], 1'b0), rotl(cd0[27:0], 1'b0)};
            round_d = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (ks.subkey_ack) begin
          if (round_q == LAST_ROUND) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            round_d = round_q + 4'd1;
            if (mode_q)
              cd_d = {rotr(cd_q[55:28], SHIFT_TWO[LAST_ROUND - round_q]),
                      rotr(cd_q[27:0],  SHIFT_TWO[LAST_ROUND - round_q])};
            else
              cd_d = {rotl(cd_q[55:28], SHIFT_TWO[round_q + 4'd1]),
                      rotl(cd_q[27:0],  SHIFT_TWO[round_q + 4'd1])};
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
`ifdef KEY_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign ks.subkey       = cd_q;
  assign ks.subkey_valid = valid_q;
  assign ks.round        = round_q;
  assign ks.busy         = busy_q;
  assign ks.done         = done_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen: vector table plus scoreboard of expected round words.
// Parity checks are compiled in when KEY_PARITY_CHECK_EN is defined.
module tb_key_schedule_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_gen_if ks ();
  key_schedule_gen #(.ROUNDS(16)) dut (.clk(clk), .rst(rst), .ks(ks));

  typedef struct {
    logic [55:0] word;
    logic [3:0]  rnd;
  } exp_t;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [55:0] first_w;
    logic [55:0] last_w;
  } vec_t;

  localparam logic [63:0] MAIN_KEY = 64'h133457799BBCDFF1;
  localparam logic [55:0] MAIN_CD0 = 56'hF0CCAAF556678F;
  localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  exp_t        sb [$];
  logic [55:0] got_w [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: total left rotation of CD0 up to each round, no per-round stepping.
  function automatic logic [27:0] rl(input logic [27:0] x, input int n);
    logic [55:0] dbl;
    dbl = {x, x};
    return dbl[55 - (n % 28) -: 28];
  endfunction

  function automatic logic [55:0] model_word(input logic [55:0] cd0, input logic dec, input int r);
    int idx;
    idx = dec ? 15 - r : r;
    return {rl(cd0[55:28], CUM[idx]), rl(cd0[27:0], CUM[idx])};
  endfunction

  task automatic do_start(input logic [63:0] k, input logic dec);
    @(negedge clk);
    ks.start   = 1'b1;
    ks.key     = k;
    ks.decrypt = dec;
    @(negedge clk);
    ks.start   = 1'b0;
  endtask

  task automatic run_sched(input logic [63:0] k, input logic dec, input logic [55:0] cd0,
                           input bit gaps, input int hold_round, input int poke_round);
    int          cyc;
    int          held;
    int          popped;
    bit          poked;
    logic        a;
    exp_t        e;
    for (int r = 0; r < 16; r++) sb.push_back('{model_word(cd0, dec, r), 4'(r)});
    do_start(k, dec);
    check("start_latency_valid", ks.subkey_valid, 1'b1);
    cyc = 0; held = 0; popped = 0; poked = 0;
    while (sb.size() > 0 && cyc < 300) begin
      a = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (ks.subkey_valid && int'(ks.round) == hold_round && held < 4) begin
        a = 1'b0;
        held++;
        check("hold_word", ks.subkey, sb[0].word);
        check("hold_round", ks.round, sb[0].rnd);
      end
      if (ks.subkey_valid && int'(ks.round) == poke_round && !poked) begin
        ks.start   = 1'b1;
        ks.key     = ~k;
        ks.decrypt = ~dec;
        poked      = 1'b1;
      end else begin
        ks.start = 1'b0;
      end
      ks.subkey_ack = a;
      if (ks.subkey_valid && a) begin
        e = sb.pop_front();
        check("word", ks.subkey, e.word);
        check("round", ks.round, e.rnd);
        got_w[popped] = ks.subkey;
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    ks.start = 1'b0;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL schedule_timeout: %0d words left after %0d cycles, expected 0", sb.size(), cyc);
      sb.delete();
    end
    if (!gaps) check("cycle_count", 64'(cyc), 64'(16 + (hold_round >= 0 ? 4 : 0)));
    check("done_pulse", ks.done, 1'b1);
    check("done_busy", ks.busy, 1'b0);
    check("done_valid", ks.subkey_valid, 1'b0);
    check("retain_word", ks.subkey, got_w[15]);
    ks.subkey_ack = 1'b0;
    @(negedge clk);
    check("done_cleared", ks.done, 1'b0);
  endtask

  vec_t vecs [7];

  initial begin
    int budget;
    vecs[0] = '{MAIN_KEY, 1'b0, 56'hE19955FAACCF1E, 56'hF0CCAAF556678F};
    vecs[1] = '{MAIN_KEY, 1'b1, 56'hF0CCAAF556678F, 56'hE19955FAACCF1E};
    vecs[2] = '{64'h8001010101010101, 1'b0, 56'h02000000000000, 56'h01000000000000};
    vecs[3] = '{64'h8001010101010101, 1'b1, 56'h01000000000000, 56'h02000000000000};
    vecs[4] = '{64'h1001010101010101, 1'b0, 56'h00000000000002, 56'h00000000000001};
    vecs[5] = '{64'h0101010101010102, 1'b0, 56'h00000000000001, 56'h00000008000000};
    vecs[6] = '{64'h0101010101010101, 1'b1, 56'h00000000000000, 56'h00000000000000};

    ks.start = 1'b0; ks.key = '0; ks.decrypt = 1'b0; ks.subkey_ack = 1'b0;

    #12;
    check("rst_subkey", ks.subkey, '0);
    check("rst_valid", ks.subkey_valid, 1'b0);
    check("rst_round", ks.round, '0);
    check("rst_busy", ks.busy, 1'b0);
    check("rst_done", ks.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_valid", ks.subkey_valid, 1'b0);
    check("idle_busy", ks.busy, 1'b0);

    foreach (vecs[i]) begin
      run_sched(vecs[i].key, vecs[i].dec,
                vecs[i].dec ? vecs[i].first_w : vecs[i].last_w, 1'b0, -1, -1);
      check("vec_first", got_w[0], vecs[i].first_w);
      check("vec_last", got_w[15], vecs[i].last_w);
      if (vecs[i].key == MAIN_KEY && vecs[i].dec) check("dec_round1", got_w[1], 56'hF866557AAB33C7);
    end

    run_sched(MAIN_KEY, 1'b0, MAIN_CD0, 1'b0, 3, -1);
    run_sched(MAIN_KEY, 1'b0, MAIN_CD0, 1'b1, -1, -1);
    run_sched(MAIN_KEY, 1'b1, MAIN_CD0, 1'b1, -1, -1);
    run_sched(MAIN_KEY, 1'b0, MAIN_CD0, 1'b0, -1, 7);

    do_start(MAIN_KEY, 1'b0);
    ks.subkey_ack = 1'b1;
    budget = 0;
    while (ks.round != 4'd9 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check("reach_round9", ks.round, 4'd9);
    #3 rst = 1'b1;
    #1;
    check("abort_subkey", ks.subkey, '0);
    check("abort_valid", ks.subkey_valid, 1'b0);
    check("abort_round", ks.round, '0);
    check("abort_busy", ks.busy, 1'b0);
    check("abort_done", ks.done, 1'b0);
    ks.subkey_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", ks.done, 1'b0);
    run_sched(MAIN_KEY, 1'b0, MAIN_CD0, 1'b0, -1, -1);

`ifdef KEY_PARITY_CHECK_EN
    do_start(64'h0, 1'b0);
    check("perr_set", ks.parity_err, 1'b1);
    check("perr_busy", ks.busy, 1'b0);
    check("perr_valid", ks.subkey_valid, 1'b0);
    @(negedge clk);
    check("perr_pulse", ks.parity_err, 1'b0);
    check("perr_still_idle", ks.busy, 1'b0);
    run_sched(MAIN_KEY, 1'b0, MAIN_CD0, 1'b0, -1, -1);
    check("perr_good_key", ks.parity_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_schedule_gen.md
Name: key_schedule_gen

Overview:
- Sequential DES key-schedule generator. Loads a 64-bit key, applies PC-1, then steps the 28-bit C/D halves through the 16-round rotation schedule.
- Presents one 56-bit C||D word per round, and the downstream PC-2 stage turns each word into a round subkey.
- Sits between the key register and PC-2. Supports encrypt order (left rotations) and decrypt order (right rotations).
- Uses a valid/ack handshake so the round datapath can stall it.

Parameters:
ROUNDS, 16, number of subkeys issued per key (fixed DES value; round counter is 4 bits + done flag)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to load key and begin schedule; sampled only in IDLE
key  input  64  DES key, FIPS 46-3 bit n at index 64-n (bit 1 = MSB); parity bits ignored by PC-1
decrypt  input  1  sampled with start; 0 = encrypt order K1..K16, 1 = decrypt order K16..K1
subkey_ack  input  1  consumer accepts current subkey when subkey_valid=1
subkey  output  56  C||D for current round, DES bit n at index 56-n (C in [55:28], D in [27:0])
subkey_valid  output  1  subkey holds a valid round word
round  output  4  round index of current subkey, 0 = round 1 ... 15 = round 16
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after round-16 word is acked

Behaviour:
- Reset (async, rst=1): state=IDLE; subkey=0, subkey_valid=0, round=0, busy=0, done=0; C/D regs cleared; latched mode cleared.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - start=1 -> latch decrypt, compute C0/D0 = PC-1(key).
  - Encrypt: load C/D = C0/D0 rotated left by shift[1]=1.
  - Decrypt: load C/D = C0/D0 unrotated (CD16 = CD0).
  - round=0, busy=1, go to ISSUE.
  - Latency: subkey_valid rises the cycle after start.
- ISSUE: subkey_valid=1; subkey, round held stable while subkey_ack=0.
  - ack with round<15 -> next cycle round+1 and C/D updated; subkey_valid stays 1 (one subkey per cycle under continuous ack).
  - Encrypt update: rotate left by shift[r+1].
  - Decrypt update: rotate right by shift[17-r], where r is the 1-based round just acked.
  - Shift schedule shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Rotations are 28-bit circular, applied to C and D independently.
  - ack with round=15 -> subkey_valid=0, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. subkey retains the last word.
- start while busy or in FIN: ignored, and key/decrypt are not sampled.
- start and ack in the same IDLE cycle: ack has no effect.
- Cumulative rotation after 16 encrypt rounds is exactly 28, so CD16 == CD0. The decrypt first word equals the encrypt last word.
- Reset mid-schedule aborts immediately: no done pulse, all outputs return to reset values.
- No combinational path from subkey_ack to subkey_valid; all outputs are registered.

Optional Feature:
- Macro KEY_PARITY_CHECK_EN.
- Defined:
  - Adds output parity_err (1 bit, reset 0).
  - On start in IDLE, each key byte is checked for odd parity.
  - Any even-parity byte: parity_err=1 for one cycle, schedule does not start, state stays IDLE, busy stays 0.
  - Otherwise behaves as normal start and parity_err=0.
- Not defined: no parity_err port; parity bits fully ignored.

Test Plan:
- Reset: assert rst mid-cycle with no clock -> all outputs 0 immediately; release, idle 5 cycles -> subkey_valid=0, busy=0.
- Encrypt, ack tied 1:
  - key=64'h133457799BBCDFF1, decrypt=0, start.
  - Next cycle: subkey=56'hE19955FAACCF1E, round=0.
  - 16 consecutive valid cycles; round 15 subkey=56'hF0CCAAF556678F.
  - done pulses one cycle after the last word, then busy=0.
- Decrypt, same key, decrypt=1:
  - Round 0 subkey=56'hF0CCAAF556678F.
  - Round 1 subkey=56'hF866557AAB33C7.
  - Round 15 subkey=56'hE19955FAACCF1E.
- Backpressure: hold ack=0 for 4 cycles at round 3 -> subkey and round stable, valid=1; then ack -> round 4 next cycle. Random ack gaps -> words identical to continuous run.
- Start while busy, plus mid-schedule reset:
  - Pulse start with a different key at round 7 -> ignored, sequence unchanged.
  - rst at round 9 -> no done; new start restarts at round 0.
- KEY_PARITY_CHECK_EN:
  - key=64'h0 -> parity_err=1 one cycle, busy stays 0.
  - key=64'h133457799BBCDFF1 -> normal start, parity_err=0.
